// File: rtl/gerador_minas.sv
// Clears a largura x altura field, then places min(max_minas, N-9) mines at distinct LFSR-picked cells.
// One write per clear cycle and 4+ cycles per placement; start is ignored while busy, no other backpressure.
module gerador_minas #(
  parameter logic [15:0] SEMENTE = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] largura,
  input  logic [7:0] altura,
  input  logic [9:0] max_minas,
  input  logic [9:0] safe_x,
  input  logic [9:0] safe_y,
  input  logic       rd_mina,
  output logic [9:0] rd_x,
  output logic [9:0] rd_y,
  output logic       wr_en,
  output logic [9:0] wr_x,
  output logic [9:0] wr_y,
  output logic       wr_mina,
  output logic       busy,
  output logic       done,
  output logic [9:0] colocadas
);
  typedef enum logic [2:0] {IDLE, LIMPA, SORTEIA, LE, CONFERE, ESCREVE, FIM} estado_t;
  estado_t estado, prox;

  logic [15:0] lfsr;
  logic [7:0]  larg_q, alt_q, mask_x, mask_y, lim_x, lim_y, cand_x, cand_y, cx, cy;
  logic [9:0]  sx_q, sy_q, alvo, alvo_calc;
  logic [15:0] n_celulas;
  logic        aceita, rejeita, fim_limpa;

  function automatic logic [7:0] mascara(input logic [7:0] v);
    logic [7:0] m;
    m = v - 8'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

  function automatic logic perto(input logic [7:0] c, input logic [9:0] s);
    logic [10:0] d;
    d = ({3'd0, c} >= {1'b0, s}) ? ({3'd0, c} - {1'b0, s}) : ({1'b0, s} - {3'd0, c});
    return d <= 11'd1;
  endfunction

  always_comb begin
    n_celulas = {8'd0, largura} * {8'd0, altura};
    alvo_calc = '0;
    if (n_celulas > 16'd9)
      alvo_calc = ((n_celulas - 16'd9) < {6'd0, max_minas}) ? 10'(n_celulas - 16'd9) : max_minas;
  end

  assign aceita    = start && (estado == IDLE || estado == FIM);
  assign cx        = lfsr[7:0] & mask_x;
  assign cy        = lfsr[15:8] & mask_y;
  assign rejeita   = (cx >= larg_q) || (cy >= alt_q) || (perto(cx, sx_q) && perto(cy, sy_q));
  assign fim_limpa = (lim_x == larg_q - 8'd1) && (lim_y == alt_q - 8'd1);

  always_ff @(posedge clk) begin
    if (reset) estado <= IDLE;
    else       estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      IDLE:    if (start) prox = LIMPA;
      LIMPA:   if (fim_limpa) prox = (alvo == 10'd0) ? FIM : SORTEIA;
      SORTEIA: if (!rejeita) prox = LE;
      LE:      prox = CONFERE;
      CONFERE: prox = rd_mina ? SORTEIA : ESCREVE;
      ESCREVE: prox = (colocadas + 10'd1 == alvo) ? FIM : SORTEIA;
      FIM:     prox = start ? LIMPA : IDLE;
      default: prox = IDLE;
    endcase
  end

  // Read address is held through LE and CONFERE so the matrix sees a stable candidate.
  always_comb begin
    busy    = 1'b0;
    wr_en   = 1'b0;
    wr_mina = 1'b0;
    wr_x    = '0;
    wr_y    = '0;
    rd_x    = '0;
    rd_y    = '0;
    case (estado)
      LIMPA: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        wr_x  = {2'd0, lim_x};
        wr_y  = {2'd0, lim_y};
      end
      SORTEIA: begin
        busy = 1'b1;
        rd_x = {2'd0, cx};
        rd_y = {2'd0, cy};
      end
      LE, CONFERE: begin
        busy = 1'b1;
        rd_x = {2'd0, cand_x};
        rd_y = {2'd0, cand_y};
      end
      ESCREVE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_mina = 1'b1;
        wr_x    = {2'd0, cand_x};
        wr_y    = {2'd0, cand_y};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= SEMENTE;
      larg_q    <= '0;
      alt_q     <= '0;
      mask_x    <= '0;
      mask_y    <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      alvo      <= '0;
      lim_x     <= '0;
      lim_y     <= '0;
      cand_x    <= '0;
      cand_y    <= '0;
      colocadas <= '0;
      done      <= 1'b0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (aceita) begin
        larg_q    <= largura;
        alt_q     <= altura;
        mask_x    <= mascara(largura);
        mask_y    <= mascara(altura);
        sx_q      <= safe_x;
        sy_q      <= safe_y;
        alvo      <= alvo_calc;
        lim_x     <= '0;
        lim_y     <= '0;
        colocadas <= '0;
        done      <= 1'b0;
      end
      if (estado == LIMPA) begin
        if (lim_x == larg_q - 8'd1) begin
          lim_x <= '0;
          lim_y <= lim_y + 8'd1;
        end else begin
          lim_x <= lim_x + 8'd1;
        end
      end
      if (estado == SORTEIA && !rejeita) begin
        cand_x <= cx;
        cand_y <= cy;
      end
      if (estado == ESCREVE) colocadas <= colocadas + 10'd1;
      if (estado != FIM && prox == FIM) done <= 1'b1;
    end
  end
endmodule

// File: doc/gerador_minas.md
# gerador_minas

Mine-placement engine for the minesweeper core, upstream of the mine matrix. On `start` it clears every cell of a `largura` × `altura` field, then places a target number of mines at pseudo-random, distinct positions. The 3×3 neighbourhood of the first-opened cell (`safe_x`, `safe_y`) is always left mine-free. It drives the matrix through a one-cell write port and checks occupancy through a one-cycle-latency read port.

## Interface
- `SEMENTE`, default 16'hACE1: LFSR value loaded on reset; must be nonzero.
- `clk` input 1: 50 MHz system clock (CLOCK_50).
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle request to generate a field; ignored while `busy`=1.
- `largura` input 8: field width in cells.
- `altura` input 8: field height in cells.
- `max_minas` input 10: requested mine count.
- `safe_x`, `safe_y` input 10 each: protected cell coordinates.
- `rd_mina` input 1: mine bit of the cell at `rd_x`/`rd_y`, valid one cycle after the address is presented.
- `rd_x`, `rd_y` output 10 each: read address.
- `wr_en` output 1: write strobe.
- `wr_x`, `wr_y` output 10 each: write address.
- `wr_mina` output 1: value to write.
- `busy` output 1: generation in progress.
- `done` output 1: level signal; field complete.
- `colocadas` output 10: mines placed so far.

## Operation
- LFSR: 16-bit Galois, taps 0xB400, shifts right every cycle in every state, reloaded with `SEMENTE` on reset.
- Candidate sampling:
  - `cx = lfsr[7:0] & mask_x` and `cy = lfsr[15:8] & mask_y`.
  - `mask_x` is the smallest 2^k−1 ≥ `largura`−1; `mask_y` is derived the same way from `altura`.
- Target count: `alvo = min(max_minas, N−9)` when `N = largura*altura > 9`, otherwise 0. `N` is computed at 16-bit width.
- States:
  - IDLE: `busy`=0. On `start`, latch all inputs, set `colocadas`=0, clear `done`, and go to LIMPA.
  - LIMPA: raster x-fastest from (0,0) to (`largura`−1, `altura`−1). One write per cycle with `wr_en`=1 and `wr_mina`=0. After the last cell, go to SORTEIA, or to FIM if `alvo`=0.
  - SORTEIA: sample (`cx`,`cy`).
    - Reject (stay in SORTEIA) if `cx` ≥ `largura`, `cy` ≥ `altura`, or |`cx`−`safe_x`| ≤ 1 and |`cy`−`safe_y`| ≤ 1.
    - Otherwise drive `rd_x`/`rd_y` and go to LE.
  - LE: wait one cycle for `rd_mina`, then go to CONFERE.
  - CONFERE: if `rd_mina`=1, go to SORTEIA. Otherwise go to ESCREVE.
  - ESCREVE: `wr_en`=1, `wr_mina`=1 at the candidate cell, `colocadas`+1. Go to FIM if `colocadas`+1 = `alvo`, otherwise go to SORTEIA.
  - FIM: `done`=1, `busy`=0. Go to IDLE. `done` holds until the next accepted `start` or reset.
- Write ports are 0 when `wr_en`=0.
- Only latched inputs are used mid-generation; input changes after `start` have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `wr_en`=0, `wr_mina`=0, `colocadas`=0, all address outputs 0, state IDLE, LFSR=`SEMENTE`.
- Reset asserted in any state aborts within the same edge. No further writes occur; a partially written field is left as-is.
- `busy` rises the cycle after `start` is sampled.
- First clear write occurs in that same cycle.
- Clearing takes exactly `N` cycles.
- Each accepted placement costs 4 cycles: SORTEIA, LE, CONFERE, ESCREVE. Each rejection adds 1 cycle (sampling reject) or 3 cycles (occupied cell).
- `done` rises one cycle after the final ESCREVE.
- `start` together with `reset`: reset wins.
- `start` while `busy`=1 is ignored.
- `start` in FIM or IDLE with `done`=1 is accepted.

## Test plan
- 16×12 field, `max_minas`=38, safe (5,5): exactly 192 clear writes, then 38 distinct `wr_mina`=1 writes. None fall in x 4..6 / y 4..6. Final `colocadas`=38 and `done`=1.
- 3×3 field, `max_minas`=5: `alvo`=0. Nine clear writes, then `done` asserts with zero mine writes.
- 4×3 field, `max_minas`=99, safe (0,0): `alvo`=3, exactly 3 mines placed, all outside the (0..1,0..1) cells.
- Matrix model returning `rd_mina`=1 for a preloaded cell: that cell is never rewritten, and `colocadas` does not increment on that candidate.
- Reset asserted mid-LIMPA (cycle 50) and mid-SORTEIA: next cycle `busy`=0 and `wr_en`=0. A following `start` restarts the sequence from clear of (0,0).
- `start` pulsed again while `busy`: no effect on the write trace. Same `start` cycle after reset with the same `SEMENTE` gives an identical write trace.
